conv3x3_stream: RTL

//  Parametrised 3x3 per-channel convolution on a raster-order RGB pixel stream (dstream valid/ready).

---
 rtl/conv3x3_stream.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// 3x3 per-channel convolution over a raster RGB stream with two line buffers,
// per-frame kernel/shift/mode latching, border zeroing, saturation and backpressure.

module conv3x3_ch #(
  parameter int CH_W    = 10,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld1_i,
  input  logic                   ld2_i,
  input  logic [8:0][CH_W-1:0]   win_i,
  input  logic [9*COEF_W-1:0]    coef_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  input  logic [1:0]             mode_i,
  input  logic                   border_i,
  output logic [CH_W-1:0]        y_o
);
  localparam int PW = CH_W + 1 + COEF_W;
  localparam int SW = PW + 4;
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** CH_W) - 1);

  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic [CH_W-1:0]      ctr_q, y_q, y_d;
  logic signed [SW-1:0] sum, shd, mag;

  always_comb begin
    for (int i = 0; i < 9; i++)
      prod_d[i] = PW'($signed({1'b0, win_i[i]})) * PW'($signed(coef_i[i*COEF_W +: COEF_W]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + SW'(prod_q[i]);
    shd = sum >>> shift_i;
    mag = (mode_i == 2'd2 && shd < 0) ? -shd : shd;
    y_d = ctr_q;
    if (mode_i == 2'd1 || mode_i == 2'd2) begin
      if (border_i || mag < 0) y_d = '0;
      else if (mag > MAXV)     y_d = '1;
      else                     y_d = mag[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '{default: '0};
      ctr_q  <= '0;
      y_q    <= '0;
    end else begin
      if (ld1_i) begin
        prod_q <= prod_d;
        ctr_q  <= win_i[4];
      end
      if (ld2_i) y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module conv3x3_stream #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int N_CH    = 3,
  parameter int CH_W    = 10,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*CH_W-1:0]   x_data_i,
  input  logic                   x_valid_i,
  output logic                   x_ready_o,
  output logic [N_CH*CH_W-1:0]   y_data_o,
  output logic                   y_valid_o,
  input  logic                   y_ready_i,
  input  logic [9*COEF_W-1:0]    coef_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  input  logic [1:0]             mode_i
);
  localparam int DW  = N_CH * CH_W;
  localparam int CW  = $clog2(WIDTH);
  localparam int RW  = $clog2(HEIGHT);
  localparam int PCW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [PCW-1:0] PRIME_N  = PCW'(WIDTH + 1);

  logic adv, acc, ld2, primed, frame_start, flush, border;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [PCW-1:0] prime_q;
  logic [9*COEF_W-1:0] coef_q;
  logic [SHIFT_W-1:0]  shift_q, s1_shift_q;
  logic [1:0]          mode_q, mode_prv_q, eff_mode, s1_mode_q;
  logic                s1_vld_q, s1_border_q, y_valid_q;

  logic [DW-1:0]            lb0_mem [WIDTH];
  logic [DW-1:0]            lb1_mem [WIDTH];
  logic [2:0][1:0][DW-1:0]  win_q;
  logic [2:0][DW-1:0]       ncol;
  logic [8:0][DW-1:0]       win;

  assign adv       = ~y_valid_q | y_ready_i;
  assign x_ready_o = adv;
  assign acc       = x_valid_i & adv;
  assign ld2       = adv & s1_vld_q;
  assign y_valid_o = y_valid_q;

  assign primed      = (prime_q == PRIME_N);
  assign frame_start = (col_q == '0) && (row_q == '0);
  // The first WIDTH+1 inputs of a frame complete windows centred in the previous frame.
  assign flush       = (row_q == '0) || (row_q == RW'(1) && col_q == '0);
  assign eff_mode    = (flush && !frame_start) ? mode_prv_q : mode_q;
  assign border      = (col_q <= CW'(1)) || (row_q <= RW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      prime_q     <= '0;
      coef_q      <= '0;
      shift_q     <= '0;
      mode_q      <= '0;
      mode_prv_q  <= '0;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_mode_q   <= '0;
      s1_shift_q  <= '0;
      y_valid_q   <= 1'b0;
    end else begin
      if (acc) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (!primed) prime_q <= prime_q + 1'b1;
        if (frame_start) begin
          mode_prv_q <= mode_q;
          coef_q     <= coef_i;
          shift_q    <= shift_i;
          mode_q     <= mode_i;
        end
        s1_border_q <= border;
        s1_mode_q   <= eff_mode;
        s1_shift_q  <= shift_q;
      end
      if (adv) begin
        s1_vld_q  <= acc & primed;
        y_valid_q <= s1_vld_q;
      end
    end
  end

  assign ncol[0] = lb1_mem[col_q];
  assign ncol[1] = lb0_mem[col_q];
  assign ncol[2] = x_data_i;

  always_ff @(posedge clk) begin
    if (acc) begin
      lb0_mem[col_q] <= x_data_i;
      lb1_mem[col_q] <= lb0_mem[col_q];
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= ncol[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r*3]     = win_q[r][0];
      win[r*3 + 1] = win_q[r][1];
      win[r*3 + 2] = ncol[r];
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [8:0][CH_W-1:0] wch;
    always_comb begin
      for (int i = 0; i < 9; i++) wch[i] = win[i][ch*CH_W +: CH_W];
    end
    conv3x3_ch #(.CH_W(CH_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld1_i    (acc),
      .ld2_i    (ld2),
      .win_i    (wch),
      .coef_i   (coef_q),
      .shift_i  (s1_shift_q),
      .mode_i   (s1_mode_q),
      .border_i (s1_border_q),
      .y_o      (y_data_o[ch*CH_W +: CH_W])
    );
  end
endmodule
